cpu_wb_arbiter: RTL and testbench
=================================

Name: cpu_wb_arbiter

Overview:
Shares one register-bank write port between two sources: the in-order ALU/memory writeback path ("main") and the multi-cycle multiplier ("mul").
- Main has priority.
- Mul results are buffered in a small queue.
- An age counter prevents mul starvation.
- A register-address conflict check keeps write-after-write order correct.
- Sits between the writeback stage / multiplier outputs and the single bank_reg write port, and stalls the main pipe when needed.

Parameters:
REG_ADDR_W, 5, register index width
DATA_W, 32, register data width
MUL_Q_DEPTH, 4, mul result queue entries (power of two, >=2)
MAX_WAIT, 8, cycles the queue head may wait before it is forced through (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
main_valid  in  1  main writeback request this cycle
main_rd  in  REG_ADDR_W  main destination register
main_data  in  DATA_W  main write data (mem or ALU result already selected)
main_stall  out  1  main request not taken; hold main_* stable
mul_valid  in  1  multiplier result valid
mul_rd  in  REG_ADDR_W  multiplier destination register
mul_data  in  DATA_W  multiplier result
mul_ready  out  1  queue can accept; transfer when mul_valid && mul_ready
wr_en  out  1  register bank write enable (registered)
wr_reg  out  REG_ADDR_W  register bank write index (registered)
wr_data  out  DATA_W  register bank write data (registered)
mul_pending  out  $clog2(MUL_Q_DEPTH+1)  queued mul entries

Behaviour:
- Clock and reset: single clock `clock`. Reset `reset` is synchronous and active-high.
- Reset:
  - Queue is emptied; any in-flight entries are discarded, including mid-operation.
  - wait_cnt=0; wr_en=0, wr_reg=0, wr_data=0; mul_pending=0.
  - While reset is high: mul_ready=0 and main_stall=0.
- Queue:
  - FIFO of {rd, data}.
  - mul_ready = !full (from registered state).
  - Push on mul_valid && mul_ready.
  - No bypass: an accepted mul result is written at the earliest in the cycle after the next edge (2-cycle latency, accept to wr_en).
- Conflict: conflict = main_valid && (main_rd equals rd of any valid queued entry). The incoming mul beat in the same cycle is NOT compared.
- Force: force = queue non-empty && (wait_cnt == MAX_WAIT || conflict).
- Grant, evaluated combinationally each cycle, priority order:
  1. force: pop head, schedule head write; main_stall = main_valid.
  2. main_valid: schedule main write; main_stall = 0.
  3. queue non-empty: pop head, schedule head write.
  4. else: no write.
- Write port: the scheduled write is registered into wr_en/wr_reg/wr_data at the clock edge, giving 1-cycle latency for main. With no write scheduled, wr_en=0 and wr_reg/wr_data hold their last values.
- wait_cnt:
  - Cleared to 0 when the queue is empty or the head is popped.
  - Otherwise increments, saturating at MAX_WAIT.
  - A newly exposed head starts at 0.
- A stalled main request is re-evaluated every cycle. Under repeated conflict it waits until every matching queued entry has drained, which guarantees the older mul write lands first.
- Push and pop in the same cycle are allowed; occupancy is unchanged. When full, no push occurs (mul_ready=0) even if a pop happens that cycle.
- mul_pending reflects registered occupancy.
- Exactly one write per cycle on the port; the two sources are never merged.

Decomposition:
- Package cpu_wb_pkg:
  - wb_req_t struct {rd, data}
  - default REG_ADDR_W / DATA_W constants
  - grant enum {GNT_NONE, GNT_MAIN, GNT_MUL}
- Sub-module cpu_wb_queue: synchronous FIFO of wb_req_t with a per-entry rd-match vector output for a given compare index. The top holds arbitration, wait_cnt, and the output registers.

Test Plan:
- Reset, then main_valid=1, rd=3, data=0xA5 for one cycle, no mul -> next cycle wr_en=1, wr_reg=3, wr_data=0xA5; main_stall=0 throughout.
- Queue empty, mul beat rd=7, data=0x1234 accepted at edge E, main idle -> wr_en=1 with rd=7/0x1234 in the cycle after E+1; mul_pending goes 1 then 0.
- Main valid every cycle with distinct rds (1,2,3,...) and one mul beat rd=9 queued, MAX_WAIT=8 -> main written for 8 cycles, then on forced cycle main_stall=1 and rd=9 written; the stalled main rd is written the following cycle.
- Queue holds rd=5; main arrives rd=5, data=0xBEEF -> main_stall=1, queue head rd=5 written first, then main 0xBEEF written next cycle (final value 0xBEEF).
- Fill 4 mul beats while main_valid=1 continuously -> mul_ready=0 after 4th accept, mul_valid held high not accepted, no entry lost or duplicated once drained.
- Assert reset with 3 entries queued and main stalled -> next cycle wr_en=0, mul_pending=0, mul_ready=0 during reset, 1 after; no queued entry is ever written.

Source files
------------

// File: rtl/cpu_wb_pkg.sv
// rtl/cpu_wb_pkg.sv - shared types and default widths for the writeback arbiter
package cpu_wb_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int DATA_W_DEF     = 32;

    typedef struct packed {
        logic [REG_ADDR_W_DEF-1:0] rd;
        logic [DATA_W_DEF-1:0]     data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_MAIN = 2'd1,
        GNT_MUL  = 2'd2
    } grant_e;

endpackage

// File: rtl/cpu_wb_queue.sv
// rtl/cpu_wb_queue.sv - mul result FIFO with per-entry destination-register match vector
module cpu_wb_queue #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [REG_ADDR_W-1:0]        push_rd_i,
    input  logic [DATA_W-1:0]            push_data_i,
    input  logic                         pop_i,
    output logic [REG_ADDR_W-1:0]        head_rd_o,
    output logic [DATA_W-1:0]            head_data_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    input  logic [REG_ADDR_W-1:0]        cmp_rd_i,
    output logic [DEPTH-1:0]             match_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0]     data_mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) begin
            rd_mem[wr_ptr_q]   <= push_rd_i;
            data_mem[wr_ptr_q] <= push_data_i;
        end
    end

    // An entry is live when its distance from the read pointer is below occupancy.
    always_comb begin
        logic [AW-1:0] offset;
        offset  = '0;
        match_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset     = AW'(i) - rd_ptr_q;
            match_o[i] = (CW'(offset) < count_q) && (rd_mem[i] == cmp_rd_i);
        end
    end

    assign head_rd_o   = rd_mem[rd_ptr_q];
    assign head_data_o = data_mem[rd_ptr_q];
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CW'(DEPTH));
    assign count_o     = count_q;

endmodule

// File: rtl/cpu_wb_arbiter.sv
// rtl/cpu_wb_arbiter.sv - arbitrates main writeback and queued mul results onto one register write port
module cpu_wb_arbiter
    import cpu_wb_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MUL_Q_DEPTH = 4,
    parameter int MAX_WAIT    = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               main_valid,
    input  logic [REG_ADDR_W-1:0]              main_rd,
    input  logic [DATA_W-1:0]                  main_data,
    output logic                               main_stall,
    input  logic                               mul_valid,
    input  logic [REG_ADDR_W-1:0]              mul_rd,
    input  logic [DATA_W-1:0]                  mul_data,
    output logic                               mul_ready,
    output logic                               wr_en,
    output logic [REG_ADDR_W-1:0]              wr_reg,
    output logic [DATA_W-1:0]                  wr_data,
    output logic [$clog2(MUL_Q_DEPTH+1)-1:0]   mul_pending
);
    localparam int WW = $clog2(MAX_WAIT+1);

    logic                   q_empty, q_full, q_push, q_pop;
    logic [REG_ADDR_W-1:0]  head_rd;
    logic [DATA_W-1:0]      head_data;
    logic [MUL_Q_DEPTH-1:0] match_vec;
    logic                   conflict, force_mul;
    grant_e                 grant;

    logic [WW-1:0]          wait_cnt_q, wait_cnt_d;
    logic                   wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0]  wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0]      wr_data_q, wr_data_d;

    cpu_wb_queue #(
        .REG_ADDR_W (REG_ADDR_W),
        .DATA_W     (DATA_W),
        .DEPTH      (MUL_Q_DEPTH)
    ) u_queue (
        .clock       (clock),
        .reset       (reset),
        .push_i      (q_push),
        .push_rd_i   (mul_rd),
        .push_data_i (mul_data),
        .pop_i       (q_pop),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .empty_o     (q_empty),
        .full_o      (q_full),
        .count_o     (mul_pending),
        .cmp_rd_i    (main_rd),
        .match_o     (match_vec)
    );

    assign mul_ready = !q_full && !reset;
    assign q_push    = mul_valid && mul_ready;

    // The same-cycle incoming mul beat is deliberately excluded from the conflict check.
    assign conflict  = main_valid && (|match_vec);
    assign force_mul = !q_empty && ((wait_cnt_q == WW'(MAX_WAIT)) || conflict);

    always_comb begin
        grant      = GNT_NONE;
        main_stall = 1'b0;
        if (force_mul) begin
            grant      = GNT_MUL;
            main_stall = main_valid && !reset;
        end else if (main_valid) begin
            grant = GNT_MAIN;
        end else if (!q_empty) begin
            grant = GNT_MUL;
        end
    end

    assign q_pop = (grant == GNT_MUL);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (q_empty || q_pop) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WW'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end
    end

    always_comb begin
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        case (grant)
            GNT_MAIN: begin
                wr_en_d   = 1'b1;
                wr_reg_d  = main_rd;
                wr_data_d = main_data;
            end
            GNT_MUL: begin
                wr_en_d   = 1'b1;
                wr_reg_d  = head_rd;
                wr_data_d = head_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_reg_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_reg_q   <= wr_reg_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_reg  = wr_reg_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// tb/tb_cpu_wb_arbiter.sv - directed self-checking bench for cpu_wb_arbiter
module tb_cpu_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        main_valid;
    logic [4:0]  main_rd;
    logic [31:0] main_data;
    logic        main_stall;
    logic        mul_valid;
    logic [4:0]  mul_rd;
    logic [31:0] mul_data;
    logic        mul_ready;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [2:0]  mul_pending;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    cpu_wb_arbiter #(
        .REG_ADDR_W  (5),
        .DATA_W      (32),
        .MUL_Q_DEPTH (4),
        .MAX_WAIT    (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .main_valid  (main_valid),
        .main_rd     (main_rd),
        .main_data   (main_data),
        .main_stall  (main_stall),
        .mul_valid   (mul_valid),
        .mul_rd      (mul_rd),
        .mul_data    (mul_data),
        .mul_ready   (mul_ready),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data),
        .mul_pending (mul_pending)
    );

    // Inputs change at the falling edge; registered outputs are read there too,
    // combinational outputs 1 ns later.
    task automatic idle_inputs();
        main_valid = 1'b0; main_rd = '0; main_data = '0;
        mul_valid  = 1'b0; mul_rd  = '0; mul_data  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        main_valid = 1'b1; main_rd = 5'd4; main_data = 32'h77;
        repeat (2) @(negedge clock);
        #1;
        tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
        tests_run++; if (wr_reg !== 5'd0) begin tests_failed++; $display("FAIL reset_wr_reg: got %0d want 0", wr_reg); end
        tests_run++; if (wr_data !== 32'h0) begin tests_failed++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        tests_run++; if (mul_pending !== 3'd0) begin tests_failed++; $display("FAIL reset_pending: got %0d want 0", mul_pending); end
        tests_run++; if (mul_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_mul_ready: got %0b want 0", mul_ready); end
        tests_run++; if (main_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_main_stall: got %0b want 0", main_stall); end
        @(negedge clock);
        reset = 1'b0;
        idle_inputs();
        #1;
        tests_run++; if (mul_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_mul_ready: got %0b want 1", mul_ready); end
        @(negedge clock);
    endtask

    task automatic test_main_write();
        main_valid = 1'b1; main_rd = 5'd3; main_data = 32'hA5;
        #1;
        tests_run++; if (main_stall !== 1'b0) begin tests_failed++; $display("FAIL main_stall: got %0b want 0", main_stall); end
        @(negedge clock);
        idle_inputs();
        tests_run++; if (wr_en !== 1'b1) begin tests_failed++; $display("FAIL main_wr_en: got %0b want 1", wr_en); end
        tests_run++; if (wr_reg !== 5'd3) begin tests_failed++; $display("FAIL main_wr_reg: got %0d want 3", wr_reg); end
        tests_run++; if (wr_data !== 32'hA5) begin tests_failed++; $display("FAIL main_wr_data: got %h want a5", wr_data); end
        @(negedge clock);
        tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL main_idle_wr_en: got %0b want 0", wr_en); end
        tests_run++; if (wr_reg !== 5'd3) begin tests_failed++; $display("FAIL main_hold_wr_reg: got %0d want 3", wr_reg); end
    endtask

    task automatic test_mul_latency();
        mul_valid = 1'b1; mul_rd = 5'd7; mul_data = 32'h1234;
        #1;
        tests_run++; if (mul_ready !== 1'b1) begin tests_failed++; $display("FAIL mul_ready_empty: got %0b want 1", mul_ready); end
        @(negedge clock);
        idle_inputs();
        tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL mul_no_bypass: got %0b want 0", wr_en); end
        tests_run++; if (mul_pending !== 3'd1) begin tests_failed++; $display("FAIL mul_pending_1: got %0d want 1", mul_pending); end
        @(negedge clock);
        tests_run++; if (wr_en !== 1'b1) begin tests_failed++; $display("FAIL mul_wr_en: got %0b want 1", wr_en); end
        tests_run++; if (wr_reg !== 5'd7) begin tests_failed++; $display("FAIL mul_wr_reg: got %0d want 7", wr_reg); end
        tests_run++; if (wr_data !== 32'h1234) begin tests_failed++; $display("FAIL mul_wr_data: got %h want 1234", wr_data); end
        tests_run++; if (mul_pending !== 3'd0) begin tests_failed++; $display("FAIL mul_pending_0: got %0d want 0", mul_pending); end
        @(negedge clock);
    endtask

    task automatic test_starvation();
        // Main rds 16..24 never collide with the queued rd 9.
        for (int k = 0; k < 9; k++) begin
            main_valid = 1'b1; main_rd = 5'(16 + k); main_data = 32'h100 + 32'(k);
            if (k == 0) begin
                mul_valid = 1'b1; mul_rd = 5'd9; mul_data = 32'h9999;
            end else begin
                mul_valid = 1'b0;
            end
            #1;
            tests_run++; if (main_stall !== 1'b0) begin tests_failed++; $display("FAIL starve_stall_k%0d: got %0b want 0", k, main_stall); end
            @(negedge clock);
            tests_run++; if (wr_en !== 1'b1 || wr_reg !== 5'(16 + k)) begin tests_failed++; $display("FAIL starve_main_k%0d: got en=%0b reg=%0d want en=1 reg=%0d", k, wr_en, wr_reg, 16 + k); end
        end
        main_rd = 5'd25; main_data = 32'hCAFE;
        #1;
        tests_run++; if (main_stall !== 1'b1) begin tests_failed++; $display("FAIL starve_force_stall: got %0b want 1", main_stall); end
        @(negedge clock);
        tests_run++; if (wr_reg !== 5'd9 || wr_data !== 32'h9999) begin tests_failed++; $display("FAIL starve_forced_write: got reg=%0d data=%h want reg=9 data=9999", wr_reg, wr_data); end
        #1;
        tests_run++; if (main_stall !== 1'b0) begin tests_failed++; $display("FAIL starve_release_stall: got %0b want 0", main_stall); end
        @(negedge clock);
        idle_inputs();
        tests_run++; if (wr_en !== 1'b1 || wr_reg !== 5'd25 || wr_data !== 32'hCAFE) begin tests_failed++; $display("FAIL starve_stalled_main: got en=%0b reg=%0d data=%h want en=1 reg=25 data=cafe", wr_en, wr_reg, wr_data); end
        @(negedge clock);
    endtask

    task automatic test_conflict();
        main_valid = 1'b1; main_rd = 5'd10; main_data = 32'h10;
        mul_valid  = 1'b1; mul_rd  = 5'd5;  mul_data  = 32'h55;
        @(negedge clock);
        mul_valid = 1'b0;
        main_rd = 5'd5; main_data = 32'hBEEF;
        #1;
        tests_run++; if (main_stall !== 1'b1) begin tests_failed++; $display("FAIL conflict_stall: got %0b want 1", main_stall); end
        @(negedge clock);
        tests_run++; if (wr_reg !== 5'd5 || wr_data !== 32'h55) begin tests_failed++; $display("FAIL conflict_mul_first: got reg=%0d data=%h want reg=5 data=55", wr_reg, wr_data); end
        #1;
        tests_run++; if (main_stall !== 1'b0) begin tests_failed++; $display("FAIL conflict_release: got %0b want 0", main_stall); end
        @(negedge clock);
        idle_inputs();
        tests_run++; if (wr_en !== 1'b1 || wr_reg !== 5'd5 || wr_data !== 32'hBEEF) begin tests_failed++; $display("FAIL conflict_main_last: got en=%0b reg=%0d data=%h want en=1 reg=5 data=beef", wr_en, wr_reg, wr_data); end
        @(negedge clock);
    endtask

    task automatic test_full_queue();
        for (int k = 0; k < 6; k++) begin
            main_valid = 1'b1; main_rd = 5'(20 + k); main_data = 32'h200 + 32'(k);
            mul_valid  = 1'b1; mul_rd  = 5'(11 + (k < 4 ? k : 4)); mul_data = 32'h300 + 32'(k < 4 ? k : 4);
            #1;
            if (k >= 4) begin
                tests_run++; if (mul_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready_k%0d: got %0b want 0", k, mul_ready); end
            end
            @(negedge clock);
            tests_run++; if (wr_reg !== 5'(20 + k)) begin tests_failed++; $display("FAIL full_main_k%0d: got %0d want %0d", k, wr_reg, 20 + k); end
        end
        tests_run++; if (mul_pending !== 3'd4) begin tests_failed++; $display("FAIL full_pending: got %0d want 4", mul_pending); end
        // Full with a pop this cycle: the held beat must still not enter.
        main_valid = 1'b0;
        #1;
        tests_run++; if (mul_ready !== 1'b0) begin tests_failed++; $display("FAIL full_pop_ready: got %0b want 0", mul_ready); end
        @(negedge clock);
        mul_valid = 1'b0;
        tests_run++; if (mul_pending !== 3'd3) begin tests_failed++; $display("FAIL full_pop_pending: got %0d want 3", mul_pending); end
        tests_run++; if (wr_reg !== 5'd11 || wr_data !== 32'h300) begin tests_failed++; $display("FAIL full_drain_0: got reg=%0d data=%h want reg=11 data=300", wr_reg, wr_data); end
        for (int k = 1; k < 4; k++) begin
            @(negedge clock);
            tests_run++; if (wr_en !== 1'b1 || wr_reg !== 5'(11 + k) || wr_data !== 32'h300 + 32'(k)) begin tests_failed++; $display("FAIL full_drain_%0d: got en=%0b reg=%0d data=%h want reg=%0d", k, wr_en, wr_reg, wr_data, 11 + k); end
        end
        @(negedge clock);
        tests_run++; if (wr_en !== 1'b0 || mul_pending !== 3'd0) begin tests_failed++; $display("FAIL full_drained: got en=%0b pending=%0d want en=0 pending=0", wr_en, mul_pending); end
        idle_inputs();
        @(negedge clock);
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 3; k++) begin
            main_valid = 1'b1; main_rd = 5'(20 + k); main_data = 32'h400 + 32'(k);
            mul_valid  = 1'b1; mul_rd  = 5'(1 + k);  mul_data  = 32'h500 + 32'(k);
            @(negedge clock);
        end
        mul_valid = 1'b0;
        main_rd = 5'd3; main_data = 32'h600;
        #1;
        tests_run++; if (main_stall !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_stall: got %0b want 1", main_stall); end
        reset = 1'b1;
        #1;
        tests_run++; if (main_stall !== 1'b0 || mul_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_comb: got stall=%0b ready=%0b want 0 0", main_stall, mul_ready); end
        @(negedge clock);
        tests_run++; if (wr_en !== 1'b0 || mul_pending !== 3'd0 || wr_data !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_state: got en=%0b pending=%0d data=%h want 0 0 0", wr_en, mul_pending, wr_data); end
        reset = 1'b0;
        idle_inputs();
        #1;
        tests_run++; if (mul_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_ready: got %0b want 1", mul_ready); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_write_%0d: got en=%0b reg=%0d want en=0", k, wr_en, wr_reg); end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_main_write();
        test_mul_latency();
        test_starvation();
        test_conflict();
        test_full_queue();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
